// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: datapath width, load/store size encodings
// and the alignment rule used by the MEM and MEM/WB stages.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  // The reserved encoding is treated as a word access everywhere.
  function automatic logic is_misaligned(input size_e size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = addr_lo[0];
      default:   mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_wb_load_align.sv
// Little-endian lane extraction and sign/zero extension of a raw memory word
// for byte, half and word loads (purely combinational).
module load_align
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic [XLEN-1:0] read_data,
  input  logic [1:0]      addr_lo,
  input  size_e           size,
  input  logic            load_unsigned,
  output logic [XLEN-1:0] load_data
);

  logic [7:0]  lanes [4];
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic        byte_sign;
  logic        half_sign;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lanes[gi] = read_data[8*gi +: 8];
  end

  assign byte_val  = lanes[addr_lo];
  assign half_val  = addr_lo[1] ? {lanes[3], lanes[2]} : {lanes[1], lanes[0]};
  assign byte_sign = ~load_unsigned & byte_val[7];
  assign half_sign = ~load_unsigned & half_val[15];

  always_comb begin
    load_data = read_data;
    case (size)
      SIZE_BYTE: load_data = {{(XLEN-8){byte_sign}}, byte_val};
      SIZE_HALF: load_data = {{(XLEN-16){half_sign}}, half_val};
      default:   load_data = read_data;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: load alignment, x0 write suppression, EX bypass and
// retire counter. Define MEM_WB_MISALIGN_CHECK_EN to block misaligned load writes.
module mem_wb_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_valid,
  input  logic            mem_read,
  input  logic            mem_to_reg,
  input  logic            reg_write,
  input  logic [RA_W-1:0] rd_addr,
  input  logic [1:0]      inst_size,
  input  logic            load_unsigned,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] read_data,
  output logic            out_valid,
  output logic            wb_reg_write,
  output logic [RA_W-1:0] wb_rd_addr,
  output logic [XLEN-1:0] wb_data,
  output logic [31:0]     retire_count,
  output logic            misalign_err,
  output logic            fwd_valid,
  output logic [RA_W-1:0] fwd_rd,
  output logic [XLEN-1:0] fwd_data
);

  logic            out_valid_reg;
  logic            wb_reg_write_reg;
  logic [RA_W-1:0] wb_rd_addr_reg;
  logic [XLEN-1:0] wb_data_reg;
  logic            misalign_err_reg;
  logic [31:0]     retire_count_reg;

  logic [XLEN-1:0] load_data;
  logic            misalign_next;
  logic            wb_reg_write_next;
  logic [XLEN-1:0] wb_data_next;

  load_align #(.XLEN(XLEN)) u_load_align (
    .read_data     (read_data),
    .addr_lo       (alu_result[1:0]),
    .size          (size_e'(inst_size)),
    .load_unsigned (load_unsigned),
    .load_data     (load_data)
  );

`ifdef MEM_WB_MISALIGN_CHECK_EN
  assign misalign_next = in_valid & mem_read & is_misaligned(size_e'(inst_size), alu_result[1:0]);
`else
  logic unused_mem_read;
  assign unused_mem_read = mem_read;
  assign misalign_next   = 1'b0;
`endif

  assign wb_reg_write_next = in_valid & reg_write & (rd_addr != '0) & ~misalign_next;
  assign wb_data_next      = mem_to_reg ? load_data : alu_result;

  // Flush wins over stall; a stall freezes everything including the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg    <= 1'b0;
      wb_reg_write_reg <= 1'b0;
      wb_rd_addr_reg   <= '0;
      wb_data_reg      <= '0;
      misalign_err_reg <= 1'b0;
      retire_count_reg <= '0;
    end else if (flush) begin
      out_valid_reg    <= 1'b0;
      wb_reg_write_reg <= 1'b0;
      wb_rd_addr_reg   <= '0;
      wb_data_reg      <= '0;
      misalign_err_reg <= 1'b0;
    end else if (!stall) begin
      out_valid_reg    <= in_valid;
      wb_reg_write_reg <= wb_reg_write_next;
      wb_rd_addr_reg   <= rd_addr;
      wb_data_reg      <= wb_data_next;
      misalign_err_reg <= misalign_next;
      if (in_valid) begin
        retire_count_reg <= retire_count_reg + 32'd1;
      end
    end
  end

  assign out_valid    = out_valid_reg;
  assign wb_reg_write = wb_reg_write_reg;
  assign wb_rd_addr   = wb_rd_addr_reg;
  assign wb_data      = wb_data_reg;
  assign misalign_err = misalign_err_reg;
  assign retire_count = retire_count_reg;
  assign fwd_valid    = out_valid_reg & wb_reg_write_reg;
  assign fwd_rd       = wb_rd_addr_reg;
  assign fwd_data     = wb_data_reg;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: behavioural model compared every cycle
// plus hand-computed literal expectations for the directed vectors.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst;
  logic        stall, flush, in_valid, mem_read, mem_to_reg, reg_write;
  logic [4:0]  rd_addr;
  logic [1:0]  inst_size;
  logic        load_unsigned;
  logic [31:0] alu_result, read_data;
  logic        out_valid, wb_reg_write, misalign_err, fwd_valid;
  logic [4:0]  wb_rd_addr, fwd_rd;
  logic [31:0] wb_data, retire_count, fwd_data;

  int n_checks = 0;
  int n_fail   = 0;
  int txn      = 0;

  mem_wb_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .mem_read(mem_read), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .rd_addr(rd_addr), .inst_size(inst_size), .load_unsigned(load_unsigned),
    .alu_result(alu_result), .read_data(read_data),
    .out_valid(out_valid), .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr),
    .wb_data(wb_data), .retire_count(retire_count), .misalign_err(misalign_err),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MEM_WB_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  // ---------------- behavioural model ----------------
  logic        m_valid, m_write, m_mis;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic [31:0] m_caps;
  logic [31:0] count_offset;

  function automatic logic [31:0] f_load(input logic [31:0] rdat, input logic [1:0] a,
                                         input logic [1:0] sz, input logic lu);
    logic [31:0] s;
    if (sz == 2'b00) begin
      s = (rdat >> (8 * a)) & 32'hFF;
      if (!lu && s >= 32'd128) s = s - 32'd256;
    end else if (sz == 2'b01) begin
      s = (rdat >> (16 * a[1])) & 32'hFFFF;
      if (!lu && s >= 32'd32768) s = s - 32'd65536;
    end else begin
      s = rdat;
    end
    return s;
  endfunction

  function automatic logic f_mis(input logic [1:0] sz, input logic [1:0] a);
    if (sz == 2'b00) return 1'b0;
    if (sz == 2'b01) return a[0];
    return a != 2'b00;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 0; m_write <= 0; m_mis <= 0; m_rd <= 0; m_data <= 0; m_caps <= 0;
    end else if (flush) begin
      m_valid <= 0; m_write <= 0; m_mis <= 0; m_rd <= 0; m_data <= 0;
    end else if (!stall) begin
      logic mis;
      mis = MIS_EN && in_valid && mem_read && f_mis(inst_size, alu_result[1:0]);
      m_valid <= in_valid;
      m_mis   <= mis;
      m_write <= in_valid && reg_write && (rd_addr != 0) && !mis;
      m_rd    <= rd_addr;
      m_data  <= mem_to_reg ? f_load(read_data, alu_result[1:0], inst_size, load_unsigned)
                            : alu_result;
      if (in_valid) m_caps <= m_caps + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("out_valid",    32'(out_valid),    32'(m_valid));
      chk("wb_reg_write", 32'(wb_reg_write), 32'(m_write));
      chk("wb_rd_addr",   32'(wb_rd_addr),   32'(m_rd));
      chk("wb_data",      wb_data,           m_data);
      chk("misalign_err", 32'(misalign_err), 32'(m_mis));
      chk("retire_count", retire_count,      m_caps + count_offset);
      chk("fwd_valid",    32'(fwd_valid),    32'(m_valid & m_write));
      chk("fwd_rd",       32'(fwd_rd),       32'(m_rd));
      chk("fwd_data",     fwd_data,          m_data);
    end
  end

  task automatic drive(input logic iv, input logic mr, input logic m2r, input logic rw,
                       input logic [4:0] rd, input logic [1:0] sz, input logic lu,
                       input logic [31:0] alu, input logic [31:0] rdat,
                       input logic st, input logic fl);
    in_valid = iv; mem_read = mr; mem_to_reg = m2r; reg_write = rw; rd_addr = rd;
    inst_size = sz; load_unsigned = lu; alu_result = alu; read_data = rdat;
    stall = st; flush = fl;
    @(posedge clk);
    @(negedge clk);
    txn++;
    $display("txn %0d: v=%0b rd=%0d sz=%0d alu=%h rdat=%h st=%0b fl=%0b -> wb_data=%h we=%0b cnt=%0d",
             txn, iv, rd, sz, alu, rdat, st, fl, wb_data, wb_reg_write, retire_count);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_wb_reg_write"}, 32'(wb_reg_write), 32'd0);
    chk({tag, "_wb_rd_addr"}, 32'(wb_rd_addr), 32'd0);
    chk({tag, "_wb_data"}, wb_data, 32'd0);
    chk({tag, "_misalign"}, 32'(misalign_err), 32'd0);
    chk({tag, "_retire"}, retire_count, 32'd0);
    chk({tag, "_fwd_valid"}, 32'(fwd_valid), 32'd0);
    chk({tag, "_fwd_rd"}, 32'(fwd_rd), 32'd0);
    chk({tag, "_fwd_data"}, fwd_data, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    count_offset = 32'd0;
    rst = 1'b1;
    // An instruction sits on the inputs during reset and must be discarded.
    in_valid = 1; mem_read = 0; mem_to_reg = 0; reg_write = 1; rd_addr = 5'd7;
    inst_size = 2'b10; load_unsigned = 0; alu_result = 32'hDEAD; read_data = 0;
    stall = 0; flush = 0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    #1 rst = 1'b0;

    drive(0, 0, 0, 0, 5'd0, 2'b10, 0, 32'h0, 32'h0, 0, 0);
    chk("post_reset_count", retire_count, 32'd0);
    chk("post_reset_valid", 32'(out_valid), 32'd0);

    drive(1, 1, 1, 1, 5'd5, 2'b00, 0, 32'h1003, 32'h80112233, 0, 0);   // lb
    chk("lb_data", wb_data, 32'hFFFFFF80);
    chk("lb_we", 32'(wb_reg_write), 32'd1);
    chk("lb_fwd_rd", 32'(fwd_rd), 32'd5);

    drive(1, 1, 1, 1, 5'd6, 2'b01, 1, 32'h1002, 32'hBEEF0000, 0, 0);   // lhu
    chk("lhu_data", wb_data, 32'h0000BEEF);

    drive(1, 1, 1, 1, 5'd6, 2'b01, 0, 32'h1000, 32'h00008001, 0, 0);   // lh
    chk("lh_data", wb_data, 32'hFFFF8001);

    drive(1, 0, 0, 1, 5'd0, 2'b10, 0, 32'h5, 32'hFFFFFFFF, 0, 0);      // ALU to x0
    chk("x0_valid", 32'(out_valid), 32'd1);
    chk("x0_we", 32'(wb_reg_write), 32'd0);
    chk("x0_fwd_valid", 32'(fwd_valid), 32'd0);

    drive(1, 1, 1, 1, 5'd9, 2'b00, 1, 32'h1001, 32'h0000A500, 0, 0);   // lbu
    chk("lbu_data", wb_data, 32'h000000A5);

    drive(1, 1, 1, 1, 5'd9, 2'b00, 0, 32'h1002, 32'h00FF0000, 0, 0);   // lb lane 2
    chk("lb2_data", wb_data, 32'hFFFFFFFF);

    drive(1, 1, 1, 1, 5'd10, 2'b11, 0, 32'h2000, 32'hCAFEF00D, 0, 0);  // reserved size = word
    chk("rsvd_word", wb_data, 32'hCAFEF00D);
    chk("count_7", retire_count, 32'd7);

    drive(1, 0, 0, 1, 5'd3, 2'b10, 0, 32'h12345678, 32'h0, 0, 0);      // ALU rd=3
    chk("alu_fwd_data", fwd_data, 32'h12345678);
    chk("alu_fwd_valid", 32'(fwd_valid), 32'd1);

    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 1, 5'd4, 2'b00, 0, 32'h99 + 32'(i), 32'h11, 1, 0);
      chk("stall_data", wb_data, 32'h12345678);
      chk("stall_rd", 32'(wb_rd_addr), 32'd3);
      chk("stall_count", retire_count, 32'd8);
    end

    drive(1, 0, 0, 1, 5'd4, 2'b10, 0, 32'h44, 32'h0, 1, 1);            // flush+stall
    chk("fs_valid", 32'(out_valid), 32'd0);
    chk("fs_data", wb_data, 32'd0);
    chk("fs_rd", 32'(wb_rd_addr), 32'd0);
    chk("fs_count", retire_count, 32'd8);

    drive(1, 0, 0, 1, 5'd4, 2'b10, 0, 32'h45, 32'h0, 0, 1);            // flush alone
    chk("flush_count", retire_count, 32'd8);

    drive(1, 1, 1, 1, 5'd11, 2'b10, 0, 32'h1002, 32'hAABBCCDD, 0, 0);  // misaligned lw
    chk("mis_count", retire_count, 32'd9);
`ifdef MEM_WB_MISALIGN_CHECK_EN
    chk("mis_err", 32'(misalign_err), 32'd1);
    chk("mis_we", 32'(wb_reg_write), 32'd0);
    drive(1, 0, 0, 1, 5'd12, 2'b10, 0, 32'h77, 32'h0, 1, 0);
    chk("mis_err_held", 32'(misalign_err), 32'd1);
    drive(1, 0, 0, 1, 5'd12, 2'b10, 0, 32'h77, 32'h0, 0, 0);
    chk("mis_err_clear", 32'(misalign_err), 32'd0);
    chk("mis_next_we", 32'(wb_reg_write), 32'd1);
`else
    chk("mis_err", 32'(misalign_err), 32'd0);
    chk("mis_we", 32'(wb_reg_write), 32'd1);
    chk("mis_data", wb_data, 32'hAABBCCDD);
`endif

    drive(1, 1, 1, 1, 5'd13, 2'b01, 0, 32'h1001, 32'h00ABCD00, 0, 0);  // misaligned lh

    // Preload the counter to its maximum, then retire one instruction.
    #1 force dut.retire_count_reg = 32'hFFFFFFFF;
    count_offset = 32'hFFFFFFFF - m_caps;
    #1 release dut.retire_count_reg;
    #1 chk("preload_count", retire_count, 32'hFFFFFFFF);
    drive(1, 0, 0, 1, 5'd14, 2'b10, 0, 32'h1, 32'h0, 0, 0);
    chk("wrap_count", retire_count, 32'd0);
    drive(0, 0, 0, 1, 5'd14, 2'b10, 0, 32'h2, 32'h0, 0, 0);
    chk("idle_count", retire_count, 32'd0);
    chk("idle_valid", 32'(out_valid), 32'd0);

    drive(1, 0, 0, 1, 5'd15, 2'b10, 0, 32'h55, 32'h0, 0, 0);
    #2 rst = 1'b1;
    count_offset = 32'd0;
    #1 chk_all_zero("midrst");
    @(negedge clk);
    #1 rst = 1'b0;

    drive(1, 1, 1, 1, 5'd5, 2'b00, 0, 32'h1003, 32'h80112233, 0, 0);
    chk("after_rst_data", wb_data, 32'hFFFFFF80);
    chk("after_rst_count", retire_count, 32'd1);

    drive(0, 0, 0, 0, 5'd0, 2'b10, 0, 32'h0, 32'h0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
